// File: rtl/riscv_mem_unit.sv
// riscv_mem_unit: unified instruction/data memory for the multicycle RISC-V
// core. It takes one doubleword read or write at a time, waits a programmable
// number of cycles, then commits the access and pulses mem_ready for one cycle.
// Misaligned accesses complete normally but never touch the array.
module riscv_mem_unit #(
    parameter int    ADDR_WIDTH = 10,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic [63:0] mem_out,
    output logic        mem_ready,
    output logic        busy,
    output logic        misaligned
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [63:0]             wdata_q;
    logic                    is_wr_q;
    logic                    mis_q;
    logic [63:0]             mem_out_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    misal_q;

    logic [63:0]             mem_q [0:DEPTH-1];

    // Combinational view of the access being committed on this edge.
    logic                    req;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   c_idx;
    logic [63:0]             c_data;
    logic                    c_wr;
    logic                    c_mis;
    logic                    mem_we;
    logic                    mem_re;

    // Address bits above the array index only produce aliasing, never a fault.
    logic                    unused_addr_hi;
    assign unused_addr_hi = ^address[63:ADDR_WIDTH+3];

    assign req = mem_write | mem_read;

    // Decide whether this edge is the commit edge and which access it carries;
    // with zero latency the request commits straight from the input pins.
    always_comb begin
        commit = 1'b0;
        c_idx  = idx_q;
        c_data = wdata_q;
        c_wr   = is_wr_q;
        c_mis  = mis_q;
        case (state_q)
            S_IDLE: begin
                if (req && (LAT == 4'd0)) begin
                    commit = 1'b1;
                    c_idx  = address[ADDR_WIDTH+2:3];
                    c_data = write_data;
                    c_wr   = mem_write;
                    c_mis  = |address[2:0];
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    commit = 1'b1;
                end
            end
            default: begin
                commit = 1'b0;
            end
        endcase
        // Reset gating keeps a write from landing while reset_n is held low.
        mem_we = commit & c_wr & ~c_mis & reset_n;
        mem_re = commit & ~c_wr & ~c_mis;
    end

    // Capture the request operands when a request is accepted in IDLE.
    always_ff @(posedge clock) begin
        if (state_q == S_IDLE && req) begin
            idx_q   <= address[ADDR_WIDTH+2:3];
            wdata_q <= write_data;
            is_wr_q <= mem_write;
            mis_q   <= |address[2:0];
        end
    end

    // Storage array: written only on the commit edge of an aligned write, never reset.
    always @(posedge clock) begin
        if (mem_we) begin
            mem_q[c_idx] <= c_data;
        end
    end

    // Control FSM with registered status outputs and read-data register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            mem_out_q <= 64'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            misal_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            misal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        cnt_q  <= LAT;
                        busy_q <= 1'b1;
                        if (LAT == 4'd0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (commit) begin
                ready_q <= 1'b1;
                misal_q <= c_mis;
            end
            if (mem_re) begin
                mem_out_q <= mem_q[c_idx];
            end
        end
    end

    assign mem_out    = mem_out_q;
    assign mem_ready  = ready_q;
    assign busy       = busy_q;
    assign misaligned = misal_q;

endmodule

// File: tb/tb_riscv_mem_unit.sv
// Testbench for riscv_mem_unit: two instances (LATENCY 2 and 0) share address,
// data and reset, with separate request strobes. A transaction-level model
// keeps the expected array contents and read-data register for each instance.
module tb_riscv_mem_unit;

    localparam int AW = 10;
    localparam int L2 = 2;
    localparam int L0 = 0;

    logic        clock;
    logic        reset_n;
    logic        rd2, wr2, rd0, wr0;
    logic [63:0] addr, wdata;
    logic [63:0] out2, out0;
    logic        rdy2, busy2, mis2;
    logic        rdy0, busy0, mis0;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] mdl2 [0:1023];
    logic [63:0] mdl0 [0:1023];
    logic [63:0] out2_m, out0_m;

    riscv_mem_unit #(.ADDR_WIDTH(AW), .LATENCY(L2), .INIT_FILE("")) u_dut2 (
        .clock(clock), .reset_n(reset_n), .mem_read(rd2), .mem_write(wr2),
        .address(addr), .write_data(wdata), .mem_out(out2), .mem_ready(rdy2),
        .busy(busy2), .misaligned(mis2)
    );

    riscv_mem_unit #(.ADDR_WIDTH(AW), .LATENCY(L0), .INIT_FILE("")) u_dut0 (
        .clock(clock), .reset_n(reset_n), .mem_read(rd0), .mem_write(wr0),
        .address(addr), .write_data(wdata), .mem_out(out0), .mem_ready(rdy0),
        .busy(busy0), .misaligned(mis0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Expected behaviour n cycles after the accepting edge for one instance.
    task automatic check_cycle(input string nm, input int n, input int lat, input bit en,
                               input bit mis, input logic b, input logic r, input logic m,
                               input logic [63:0] o, input logic [63:0] oold,
                               input logic [63:0] onew);
        bit eb, er;
        eb = en && (n <= lat + 1);
        er = en && (n == lat + 1);
        check($sformatf("%s busy c%0d", nm, n), 64'(b), 64'(eb));
        check($sformatf("%s ready c%0d", nm, n), 64'(r), 64'(er));
        check($sformatf("%s misaligned c%0d", nm, n), 64'(m), 64'(er && mis));
        check($sformatf("%s mem_out c%0d", nm, n), o, (en && n >= lat + 1) ? onew : oold);
    endtask

    // One request held for a single edge, then six cycles of observation.
    task automatic access(input bit wr, input bit rd, input logic [63:0] a,
                          input logic [63:0] d, input bit en2, input bit en0,
                          input bit inject);
        int          idx;
        bit          mis;
        logic [63:0] new2, new0;
        idx  = int'((a >> 3) % 64'd1024);
        mis  = (a % 64'd8) != 0;
        addr  = a;
        wdata = d;
        wr2 = wr & en2; rd2 = rd & en2;
        wr0 = wr & en0; rd0 = rd & en0;
        @(posedge clock);
        @(negedge clock);
        wr2 = 1'b0; rd2 = 1'b0; wr0 = 1'b0; rd0 = 1'b0;
        new2 = out2_m;
        new0 = out0_m;
        if (en2 && rd && !wr && !mis) new2 = mdl2[idx];
        if (en0 && rd && !wr && !mis) new0 = mdl0[idx];
        if (en2 && wr && !mis) mdl2[idx] = d;
        if (en0 && wr && !mis) mdl0[idx] = d;
        for (int n = 1; n <= 6; n++) begin
            check_cycle("L2", n, L2, en2, mis, busy2, rdy2, mis2, out2, out2_m, new2);
            check_cycle("L0", n, L0, en0, mis, busy0, rdy0, mis0, out0, out0_m, new0);
            if (inject && n == 1) begin
                rd2   = 1'b1;
                addr  = a ^ 64'h108;
                wdata = ~d;
            end
            if (inject && n == 3) begin
                rd2   = 1'b0;
                addr  = a;
                wdata = d;
            end
            @(negedge clock);
        end
        out2_m = new2;
        out0_m = new0;
    endtask

    initial begin
        logic [63:0] a, d;
        int          idx, low, hi, op;

        reset_n = 1'b0;
        rd2 = 1'b0; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
        addr = 64'd0; wdata = 64'd0;
        out2_m = 64'd0; out0_m = 64'd0;
        for (int i = 0; i < 1024; i++) begin
            mdl2[i] = 64'd0;
            mdl0[i] = 64'd0;
        end

        repeat (3) @(negedge clock);
        check("reset busy2", 64'(busy2), 64'd0);
        check("reset ready2", 64'(rdy2), 64'd0);
        check("reset mis2", 64'(mis2), 64'd0);
        check("reset out2", out2, 64'd0);
        check("reset busy0", 64'(busy0), 64'd0);
        check("reset ready0", 64'(rdy0), 64'd0);
        check("reset mis0", 64'(mis0), 64'd0);
        check("reset out0", out0, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Fill the first 32 entries so every later read has a known value.
        for (int i = 0; i < 32; i++) begin
            access(1'b1, 1'b0, 64'(i) * 64'd8, {$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
        end

        // Boot word at address 0, then fetch it.
        access(1'b1, 1'b0, 64'h0, 64'h0000_0000_0030_0093, 1'b1, 1'b1, 1'b0);
        access(1'b0, 1'b1, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0);
        check("boot fetch", out2, 64'h0000_0000_0030_0093);

        // Write then read back.
        access(1'b1, 1'b0, 64'h40, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1, 1'b0);
        access(1'b0, 1'b1, 64'h40, 64'h0, 1'b1, 1'b1, 1'b0);

        // Misaligned read leaves mem_out alone; misaligned write leaves entry 8 alone.
        access(1'b1, 1'b0, 64'h48, 64'h55, 1'b1, 1'b1, 1'b0);
        access(1'b0, 1'b1, 64'h48, 64'h0, 1'b1, 1'b1, 1'b0);
        access(1'b0, 1'b1, 64'h43, 64'h0, 1'b1, 1'b1, 1'b0);
        check("misaligned read keeps out", out2, 64'h55);
        access(1'b1, 1'b0, 64'h41, 64'hAAAA_AAAA, 1'b1, 1'b1, 1'b0);
        access(1'b0, 1'b1, 64'h40, 64'h0, 1'b1, 1'b1, 1'b0);

        // Read and write together behave as a write.
        access(1'b1, 1'b1, 64'h80, 64'h1234, 1'b1, 1'b1, 1'b0);
        access(1'b0, 1'b1, 64'h80, 64'h0, 1'b1, 1'b1, 1'b0);

        // A request raised only while the LATENCY-2 unit waits is dropped.
        access(1'b0, 1'b1, 64'h50, 64'h0, 1'b1, 1'b0, 1'b1);

        // Address wrap at 2^13 bytes.
        access(1'b1, 1'b0, 64'h2008, 64'h77, 1'b1, 1'b1, 1'b0);
        access(1'b0, 1'b1, 64'h0008, 64'h0, 1'b1, 1'b1, 1'b0);

        // Back-to-back held requests on the zero-latency unit: one every 2 cycles.
        addr = 64'h8;
        rd0  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        for (int n = 1; n <= 6; n++) begin
            check($sformatf("b2b ready0 c%0d", n), 64'(rdy0), 64'((n % 2) == 1));
            check($sformatf("b2b busy0 c%0d", n), 64'(busy0), 64'((n % 2) == 1));
            check($sformatf("b2b out0 c%0d", n), out0, mdl0[1]);
            check($sformatf("b2b busy2 c%0d", n), 64'(busy2), 64'd0);
            if (n == 6) rd0 = 1'b0;
            @(negedge clock);
        end
        out0_m = mdl0[1];

        // Reset during WAIT drops the write; the old contents survive.
        addr  = 64'h10;
        wdata = 64'hFF;
        wr2   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wr2 = 1'b0;
        check("midwrite busy2", 64'(busy2), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async reset busy2", 64'(busy2), 64'd0);
        check("async reset ready2", 64'(rdy2), 64'd0);
        check("async reset mis2", 64'(mis2), 64'd0);
        check("async reset out2", out2, 64'd0);
        check("async reset out0", out0, 64'd0);
        out2_m = 64'd0;
        out0_m = 64'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        access(1'b0, 1'b1, 64'h10, 64'h0, 1'b1, 1'b1, 1'b0);

        // Randomized traffic over the filled region with aliasing and misalignment.
        for (int t = 0; t < 40; t++) begin
            idx = int'($urandom_range(0, 31));
            low = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            hi  = int'($urandom_range(0, 7));
            a   = (64'(hi) << 13) | (64'(idx) << 3) | 64'(low);
            d   = {$urandom, $urandom};
            op  = int'($urandom_range(0, 2));
            access(op != 1, op != 0, a, d, 1'b1, 1'b1, (t % 10) == 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
